// File: rtl/updown_seq_checker.sv
// Receive-side checker for the triangular up/down sequence 0..MAX,MAX..0,0..
// Locks onto the stream, predicts each sample, flags and counts deviations, reports periods.
module updown_seq_checker #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 locked,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 period_done,
    output logic                 dir_out
);

    localparam int unsigned          MCW      = $clog2(LOCK_COUNT + 1);
    localparam logic [WIDTH-1:0]     MaxVal   = '1;
    localparam logic [MCW-1:0]       LockCnt  = MCW'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] ErrSat   = '1;

    typedef enum logic [1:0] {StHunt, StLocking, StLocked} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             prev_valid_q;
    logic [WIDTH-1:0] shadow_val_q;
    logic             shadow_dir_q;
    logic [MCW-1:0]   match_cnt_q;

    logic [WIDTH-1:0] adv_val;
    logic             adv_dir;
    logic             match;
    logic [WIDTH:0]   prev_inc;
    logic [WIDTH:0]   prev_dec;
    logic [WIDTH:0]   in_ext;
    logic             pair_up;
    logic             pair_dn;
    logic             pair_top;
    logic             pair_bot;

    // Shadow advance: step toward the end, hold one extra sample at each end and turn.
    always_comb begin
        adv_val = shadow_val_q;
        adv_dir = shadow_dir_q;
        if (!shadow_dir_q) begin
            if (shadow_val_q != MaxVal) adv_val = shadow_val_q + 1'b1;
            else                        adv_dir = 1'b1;
        end else begin
            if (shadow_val_q != '0) adv_val = shadow_val_q - 1'b1;
            else                    adv_dir = 1'b0;
        end
    end

    assign match = (in_data == adv_val);

    // One extra bit so MAX->0 and 0->MAX never count as neighbours.
    assign in_ext   = {1'b0, in_data};
    assign prev_inc = {1'b0, prev_q} + 1'b1;
    assign prev_dec = {1'b0, prev_q} - 1'b1;
    assign pair_up  = (in_ext == prev_inc);
    assign pair_dn  = (in_ext == prev_dec);
    assign pair_top = (in_data == prev_q) && (prev_q == MaxVal);
    assign pair_bot = (in_data == prev_q) && (prev_q == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StHunt;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            shadow_val_q <= '0;
            shadow_dir_q <= 1'b0;
            match_cnt_q  <= '0;
            locked       <= 1'b0;
            error        <= 1'b0;
            err_count    <= '0;
            period_done  <= 1'b0;
            dir_out      <= 1'b0;
        end else begin
            error       <= 1'b0;
            period_done <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    StHunt: begin
                        if (!prev_valid_q) begin
                            prev_q       <= in_data;
                            prev_valid_q <= 1'b1;
                        end else if (pair_up || pair_bot) begin
                            shadow_val_q <= in_data;
                            shadow_dir_q <= 1'b0;
                            match_cnt_q  <= '0;
                            dir_out      <= 1'b0;
                            state_q      <= StLocking;
                        end else if (pair_dn || pair_top) begin
                            shadow_val_q <= in_data;
                            shadow_dir_q <= 1'b1;
                            match_cnt_q  <= '0;
                            dir_out      <= 1'b1;
                            state_q      <= StLocking;
                        end else begin
                            prev_q <= in_data;
                        end
                    end
                    StLocking: begin
                        if (match) begin
                            shadow_val_q <= adv_val;
                            shadow_dir_q <= adv_dir;
                            dir_out      <= adv_dir;
                            if (match_cnt_q + 1'b1 == LockCnt) begin
                                state_q <= StLocked;
                                locked  <= 1'b1;
                            end else begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                            end
                        end else begin
                            prev_q       <= in_data;
                            prev_valid_q <= 1'b1;
                            dir_out      <= 1'b0;
                            state_q      <= StHunt;
                        end
                    end
                    StLocked: begin
                        if (match) begin
                            shadow_val_q <= adv_val;
                            shadow_dir_q <= adv_dir;
                            dir_out      <= adv_dir;
                            // Second 0 of the trough closes a period.
                            if (shadow_val_q == '0 && shadow_dir_q) period_done <= 1'b1;
                        end else begin
                            error        <= 1'b1;
                            if (err_count != ErrSat) err_count <= err_count + 1'b1;
                            locked       <= 1'b0;
                            prev_q       <= in_data;
                            prev_valid_q <= 1'b1;
                            dir_out      <= 1'b0;
                            state_q      <= StHunt;
                        end
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_seq_checker.sv
// Directed bench for updown_seq_checker; a second instance with a 2-bit error counter
// shares the stimulus to exercise saturation.
module tb_updown_seq_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;

    logic       locked, error, period_done, dir_out;
    logic [7:0] err_count;
    logic       locked2, error2, period_done2, dir_out2;
    logic [1:0] err_count2;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] gv;
    logic       gd;

    always #5 clk = ~clk;

    updown_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .error      (error),
        .err_count  (err_count),
        .period_done(period_done),
        .dir_out    (dir_out)
    );

    updown_seq_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(2)) u_dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked2),
        .error      (error2),
        .err_count  (err_count2),
        .period_done(period_done2),
        .dir_out    (dir_out2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Reference walk of the ideal sequence.
    task automatic send_next();
        if (!gd) begin
            if (gv != 4'hf) gv = gv + 4'd1;
            else            gd = 1'b1;
        end else begin
            if (gv != 4'h0) gv = gv - 4'd1;
            else            gd = 1'b0;
        end
        send(gv);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int pulses;
        int exp_sat[5] = '{1, 2, 3, 3, 3};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        idle(2);
        check("rst_locked", locked, 0);
        check("rst_error", error, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_period", period_done, 0);
        check("rst_dir", dir_out, 0);
        reset = 1'b1;
        idle(1);

        // Acquire on 0,1 then three matches
        send(0); check("acq0_locked", locked, 0);
        send(1); check("acq1_locked", locked, 0);
        send(2);
        send(3); check("acq3_locked", locked, 0);
        send(4); check("acq4_locked", locked, 1);
        check("acq4_error", error, 0);
        gv = 4'd4; gd = 1'b0;

        // Up to the second 15
        repeat (12) send_next();
        check("peak_dir", dir_out, 1);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            send_next();
            if (period_done) pulses++;
        end
        check("first_period_last", period_done, 1);
        check("first_period_count", pulses, 1);
        check("trough_dir", dir_out, 0);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            send_next();
            if (period_done) pulses++;
            if (i == 0) check("period_one_cycle", period_done, 0);
        end
        check("second_period_last", period_done, 1);
        check("second_period_count", pulses, 1);
        check("period_errcnt", err_count, 0);

        // Error at 8 going up
        repeat (8) send_next();
        send(7);
        check("inj1_error", error, 1);
        check("inj1_errcnt", err_count, 1);
        check("inj1_errcnt_sat", err_count2, 1);
        check("inj1_locked", locked, 0);
        send(8);  check("inj1_pulse_end", error, 0);
        send(9);
        send(10); check("relock10", locked, 0);
        send(11); check("relock11", locked, 1);
        gv = 4'd11; gd = 1'b0;

        // Idle gap between 12 and 13
        send_next();
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("gap_error", error, 0);
            check("gap_locked", locked, 1);
        end
        send_next();
        check("gap_resume_error", error, 0);
        check("gap_resume_locked", locked, 1);

        // Four more injected errors, each followed by relock on 2,3,4,5,6
        for (int i = 1; i < 5; i++) begin
            send(2);
            check("inj_error", error, 1);
            check("inj_errcnt", err_count, i + 1);
            check("inj_errcnt_sat", err_count2, exp_sat[i]);
            send(3);
            send(4);
            send(5);
            check("inj_locked_pre", locked, 0);
            send(6);
            check("inj_locked", locked, 1);
        end

        // Error into HUNT, then a flat pair that is not an end value
        send(5);
        check("hunt_error", error, 1);
        check("hunt_errcnt", err_count, 6);
        check("hunt_errcnt_sat", err_count2, 3);
        send(5);
        check("hunt55_dir", dir_out, 0);
        send(5);
        check("hunt555_locked", locked, 0);
        send(15);
        send(15);
        check("top_pair_dir", dir_out, 1);
        check("top_pair_locked", locked, 0);
        send(14);
        check("top_pair_follow_dir", dir_out, 1);
        check("top_pair_follow_err", error, 0);

        // Mid-run reset
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("mid_rst_dir", dir_out, 0);
        check("mid_rst_errcnt", err_count, 0);
        check("mid_rst_errcnt_sat", err_count2, 0);
        check("mid_rst_locked", locked, 0);
        send(0);
        send(1);
        send(2);
        send(3); check("post_rst_locked3", locked, 0);
        send(4); check("post_rst_locked4", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
